// File: rtl/reset_sequencer.sv
// Power-on/reset sequencer: PLL reset hold, lock qualification, staged domain release.
// Optional WAIT_LOCK timeout with retry is enabled by defining RSTSEQ_LOCK_TIMEOUT_EN.
module reset_sequencer #(
  parameter int PWRUP_CYCLES        = 127,
  parameter int LOCK_STABLE_CYCLES  = 64,
  parameter int NUM_DOMAINS         = 3,
  parameter int STAGE_GAP_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic                   EXT_CLK_50MHz,
  input  logic                   BTN_RESET_n,
  input  logic                   pll_locked,
  input  logic                   sw_reset_req,
  output logic                   pll_areset,
  output logic [NUM_DOMAINS-1:0] domain_reset_n,
  output logic                   sys_ready,
  output logic [7:0]             lock_loss_count,
  output logic [2:0]             seq_state
);

  typedef enum logic [2:0] {
    POR_HOLD  = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
    RUN       = 3'd3,
    TIMEOUT   = 3'd4
`else
    RUN       = 3'd3
`endif
  } state_t;

  localparam int STG_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [31:0]      PWR_LAST = 32'(PWRUP_CYCLES - 1);
  localparam logic [31:0]      STB_LAST = 32'(LOCK_STABLE_CYCLES - 1);
  localparam logic [31:0]      GAP_LAST = 32'(STAGE_GAP_CYCLES - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(NUM_DOMAINS - 1);
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
  localparam logic [31:0]      TO_LAST  = 32'(LOCK_TIMEOUT_CYCLES - 1);
`endif

  if (PWRUP_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || NUM_DOMAINS < 1 || NUM_DOMAINS > 8 ||
      STAGE_GAP_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("reset_sequencer: parameter out of range");
  end

  state_t                 state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [STG_W-1:0]       stage_q, stage_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   rdy_q, rdy_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [7:0]             llc_q, llc_d;
  logic                   lock_p0, lock_p1;
  logic                   lock_s;
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
  logic [31:0]            to_cnt_q, to_cnt_d;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0/p1: two-flop synchroniser for the asynchronous lock input
  always_ff @(posedge EXT_CLK_50MHz or negedge BTN_RESET_n) begin
    if (!BTN_RESET_n) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
    end else begin
      lock_p0 <= pll_locked;
      lock_p1 <= lock_p0;
    end
  end

  assign lock_s = lock_p1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    dom_d     = dom_q;
    rdy_d     = rdy_q;
    pll_rst_d = pll_rst_q;
    llc_d     = llc_q;
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
`endif
    case (state_q)
      POR_HOLD: begin
        pll_rst_d = 1'b1;
        dom_d     = '0;
        rdy_d     = 1'b0;
        if (cnt_q == PWR_LAST) begin
          state_d   = WAIT_LOCK;
          cnt_d     = '0;
          pll_rst_d = 1'b0;
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
          to_cnt_d  = '0;
`endif
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      WAIT_LOCK: begin
        if (lock_s) begin
          if (cnt_q == STB_LAST) begin
            state_d = RELEASE;
            cnt_d   = '0;
            stage_d = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end else begin
          cnt_d = '0;
        end
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
        // A stability pass on the same edge as the timeout takes precedence.
        if (!(lock_s && cnt_q == STB_LAST)) begin
          if (to_cnt_q == TO_LAST) begin
            state_d   = TIMEOUT;
            cnt_d     = '0;
            pll_rst_d = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 32'd1;
          end
        end
`endif
      end

      RELEASE: begin
        if (!lock_s) begin
          state_d   = POR_HOLD;
          cnt_d     = '0;
          dom_d     = '0;
          rdy_d     = 1'b0;
          pll_rst_d = 1'b1;
          llc_d     = sat_inc(llc_q);
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (stage_q == STG_W'(i)) dom_d[i] = 1'b1;
          end
          if (stage_q == STG_LAST) begin
            state_d = RUN;
            rdy_d   = 1'b1;
          end else begin
            stage_d = stage_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      RUN: begin
        if (!lock_s) begin
          state_d   = POR_HOLD;
          cnt_d     = '0;
          dom_d     = '0;
          rdy_d     = 1'b0;
          pll_rst_d = 1'b1;
          llc_d     = sat_inc(llc_q);
        end else if (sw_reset_req) begin
          state_d = RELEASE;
          cnt_d   = '0;
          stage_d = '0;
          dom_d   = '0;
          rdy_d   = 1'b0;
        end
      end

`ifdef RSTSEQ_LOCK_TIMEOUT_EN
      TIMEOUT: begin
        state_d   = POR_HOLD;
        cnt_d     = '0;
        pll_rst_d = 1'b1;
      end
`endif

      default: begin
        state_d   = POR_HOLD;
        cnt_d     = '0;
        dom_d     = '0;
        rdy_d     = 1'b0;
        pll_rst_d = 1'b1;
      end
    endcase
  end

  // Stage p2: registered sequencer state and outputs
  always_ff @(posedge EXT_CLK_50MHz or negedge BTN_RESET_n) begin
    if (!BTN_RESET_n) begin
      state_q   <= POR_HOLD;
      cnt_q     <= '0;
      stage_q   <= '0;
      dom_q     <= '0;
      rdy_q     <= 1'b0;
      pll_rst_q <= 1'b1;
      llc_q     <= '0;
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      dom_q     <= dom_d;
      rdy_q     <= rdy_d;
      pll_rst_q <= pll_rst_d;
      llc_q     <= llc_d;
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  assign pll_areset      = pll_rst_q;
  assign domain_reset_n  = dom_q;
  assign sys_ready       = rdy_q;
  assign lock_loss_count = llc_q;
  assign seq_state       = state_q;

endmodule
